// File: rtl/lamp_sequencer_pkg.sv
// Shared types and lamp encodings for the lamp sequencer slice.
// Package lamp_pkg is imported by the sequencer top level.
package lamp_pkg;

  typedef enum logic [1:0] {
    S_RED    = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2
  } phase_e;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_GREEN  = 3'b010;
  localparam logic [2:0] LIGHT_YELLOW = 3'b001;

  // The unused encoding 2'b11 decodes as RED so the lamps never go dark.
  function automatic logic [2:0] light_of(input logic [1:0] st);
    case (st)
      S_GREEN:  return LIGHT_GREEN;
      S_YELLOW: return LIGHT_YELLOW;
      default:  return LIGHT_RED;
    endcase
  endfunction

  function automatic logic [1:0] phase_of(input logic [1:0] st);
    case (st)
      S_GREEN:  return S_GREEN;
      S_YELLOW: return S_YELLOW;
      default:  return S_RED;
    endcase
  endfunction

endpackage

// File: rtl/lamp_sequencer_if.sv
// Control/status bundle between the tick logic, the lamp sequencer and the lamp drivers.
interface lamp_sequencer_if;

  logic       en;
  logic       ped_req;
  logic [2:0] light;
  logic [1:0] phase;
  logic       phase_start;
  logic       ped_ack;

  modport master (
    output en, ped_req,
    input  light, phase, phase_start, ped_ack
  );

  modport slave (
    input  en, ped_req,
    output light, phase, phase_start, ped_ack
  );

endinterface

// File: rtl/lamp_sequencer_dwell_counter.sv
// Phase dwell counter: counts enabled cycles, flags the last enabled cycle of a dwell.
module dwell_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             done_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear has priority so a phase change always starts the new dwell at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = en_i && (cnt_q == term_i - 1'b1);
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/lamp_sequencer.sv
// Three-lamp sequencer RED -> GREEN -> YELLOW with per-phase dwell and run enable.
// Define LAMP_PED_EN to add the pedestrian request latch and early GREEN cut.
module lamp_sequencer
  import lamp_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int RED_TICKS    = 8,
  parameter int GREEN_TICKS  = 6,
  parameter int YELLOW_TICKS = 2,
  parameter int MIN_GREEN    = 2
) (
  input logic              clk,
  input logic              rst_n,
  lamp_sequencer_if.slave  bus
);

  localparam int TICK_LIMIT = 1 << CNT_W;

  if (RED_TICKS < 1 || RED_TICKS >= TICK_LIMIT) begin : g_bad_red
    $error("lamp_sequencer: RED_TICKS out of range");
  end
  if (GREEN_TICKS < 1 || GREEN_TICKS >= TICK_LIMIT) begin : g_bad_green
    $error("lamp_sequencer: GREEN_TICKS out of range");
  end
  if (YELLOW_TICKS < 1 || YELLOW_TICKS >= TICK_LIMIT) begin : g_bad_yellow
    $error("lamp_sequencer: YELLOW_TICKS out of range");
  end
  if (MIN_GREEN < 1 || MIN_GREEN > GREEN_TICKS) begin : g_bad_min_green
    $error("lamp_sequencer: MIN_GREEN out of range");
  end

  localparam logic [1:0] ST_RED    = S_RED;
  localparam logic [1:0] ST_GREEN  = S_GREEN;
  localparam logic [1:0] ST_YELLOW = S_YELLOW;

  localparam logic [CNT_W-1:0] RED_T    = CNT_W'(RED_TICKS);
  localparam logic [CNT_W-1:0] GREEN_T  = CNT_W'(GREEN_TICKS);
  localparam logic [CNT_W-1:0] YELLOW_T = CNT_W'(YELLOW_TICKS);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic             phase_start_q;
  logic             transition;
  logic             cut;
  logic             done;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] term;

  always_comb begin
    case (state_q)
      ST_GREEN:  term = GREEN_T;
      ST_YELLOW: term = YELLOW_T;
      default:   term = RED_T;
    endcase
  end

  dwell_counter #(
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (transition),
    .en_i    (bus.en),
    .term_i  (term),
    .done_o  (done),
    .cnt_o   (cnt)
  );

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RED:    if (done)        state_d = ST_GREEN;
      ST_GREEN:  if (done || cut) state_d = ST_YELLOW;
      ST_YELLOW: if (done)        state_d = ST_RED;
      default:                    state_d = ST_RED;
    endcase
  end

  // Every state change, including recovery from the illegal code, restarts the dwell.
  assign transition = (state_d != state_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RED;
      phase_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_start_q <= transition;
    end
  end

`ifdef LAMP_PED_EN
  localparam logic [CNT_W-1:0] MIN_GREEN_LAST = CNT_W'(MIN_GREEN - 1);

  logic ped_pend_q;
  logic ped_pend_d;
  logic ped_ack_q;

  // The cut is independent of done, so a natural end on an eligible edge still acknowledges.
  assign cut = bus.en && (state_q == ST_GREEN) && ped_pend_q && (cnt >= MIN_GREEN_LAST);

  // A request arriving while one is being served merges into it.
  assign ped_pend_d = cut ? 1'b0 : (ped_pend_q | bus.ped_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_pend_q <= 1'b0;
      ped_ack_q  <= 1'b0;
    end else begin
      ped_pend_q <= ped_pend_d;
      ped_ack_q  <= cut;
    end
  end

  assign bus.ped_ack = ped_ack_q;
`else
  logic unused_ped_req;

  assign unused_ped_req = bus.ped_req;
  assign cut            = 1'b0;
  assign bus.ped_ack    = 1'b0;
`endif

  assign bus.light       = light_of(state_q);
  assign bus.phase       = phase_of(state_q);
  assign bus.phase_start = phase_start_q;

endmodule

// File: doc/lamp_sequencer.md
# lamp_sequencer

Parametrised Moore-style lamp sequencer driving a three-lamp signal head (RED → GREEN → YELLOW → RED) with a programmable dwell time per phase, a global run enable and an optional pedestrian request that shortens GREEN. It is the configurable successor of the fixed one-cycle-per-phase lamp cycler. It sits between the system tick logic and the lamp drivers. All outputs are functions of registered state only.

## Interface
- CNT_W, 8: dwell counter width.
- RED_TICKS, 8: RED dwell in enabled cycles; legal range 1..2**CNT_W-1.
- GREEN_TICKS, 6: full GREEN dwell; legal range 1..2**CNT_W-1.
- YELLOW_TICKS, 2: YELLOW dwell; legal range 1..2**CNT_W-1.
- MIN_GREEN, 2: minimum GREEN dwell before a pedestrian cut; legal range 1..GREEN_TICKS.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  1 = dwell counter advances; 0 = state and counter frozen.
- ped_req  input  1  pedestrian request; a single-cycle pulse or a level is accepted.
- light  output  3  one-hot lamp: RED=100, GREEN=010, YELLOW=001.
- phase  output  2  current phase: 0 RED, 1 GREEN, 2 YELLOW.
- phase_start  output  1  one-cycle pulse in the first cycle of every newly entered phase.
- ped_ack  output  1  one-cycle pulse in the first YELLOW cycle after a pedestrian-shortened GREEN.

## Operation
- States: S_RED, S_GREEN, S_YELLOW. Transitions: RED→GREEN, GREEN→YELLOW, YELLOW→RED.
- Illegal encoding: go to S_RED with the counter at 0 on the next edge.
- Dwell counter `cnt`:
  - Cleared on every transition.
  - Incremented on each edge with en=1.
  - A phase ends at the edge where en=1 and cnt == TICKS-1 for that phase.
  - TICKS=1 means one cycle per phase.
- en=0: cnt, state and ped_pend hold their values. ped_req is still latched.
- Pedestrian (with LAMP_PED_EN defined):
  - ped_req=1 sets the sticky flag ped_pend.
  - Early cut occurs at an edge where en=1, state is GREEN, ped_pend=1 and cnt ≥ MIN_GREEN-1. The state then goes to YELLOW.
  - The cut clears ped_pend and registers ped_ack=1 for the following cycle.
  - If the natural GREEN end coincides with a cut-eligible edge, the result is the same: ped_pend is cleared and ped_ack pulses.
  - A request in RED or YELLOW is held and served in the next GREEN.
  - When ped_req is high in the same cycle a request is being served, the clear wins. That request is absorbed by the one being served.
- Outputs:
  - light and phase decode from state only.
  - phase_start is registered: it is 1 in the cycle after any transition edge.
- Parameter checks fail elaboration: any TICKS value of 0 or ≥ 2**CNT_W, or MIN_GREEN > GREEN_TICKS.

## Timing
- Reset values, applied asynchronously while rst_n=0 with no clock edge required:
  - state = S_RED, cnt = 0, ped_pend = 0.
  - light = 100, phase = 0, phase_start = 0, ped_ack = 0.
- Reset release: the first RED dwell counts from cnt=0. phase_start does not pulse for this first RED.
- Latency:
  - light changes in the same cycle as phase.
  - phase_start and ped_ack are valid in that same first cycle of the new phase.
- ped_req to ped_pend: one edge.
- Reset asserted mid-operation: immediately forces the reset values above, discarding any pending request.
- Period with en held at 1 and no requests: RED_TICKS + GREEN_TICKS + YELLOW_TICKS cycles.

## Configuration
- LAMP_PED_EN defined: ped_pend logic and early GREEN cut are present.
- LAMP_PED_EN undefined:
  - ped_req is ignored and ped_ack is tied to 0.
  - GREEN always lasts GREEN_TICKS.
  - Ports are unchanged.

## Structure
- Package lamp_pkg holds:
  - the phase state typedef (S_RED=0, S_GREEN=1, S_YELLOW=2);
  - light encoding constants LIGHT_RED, LIGHT_GREEN, LIGHT_YELLOW.
- Sub-module dwell_counter (CNT_W wide) provides:
  - inputs: clear, en, terminal value;
  - output: done (cnt == term-1 and en).
- The top level owns the FSM, ped_pend, and the phase_start/ped_ack registers.

## Test plan
All scenarios use the default parameters with en=1 unless stated.
- Reset release → light 100 for 8 cycles, 010 for 6, 001 for 2; repeats with period 16; phase_start pulses at each GREEN, YELLOW and RED entry.
- en=0 for 5 cycles when GREEN cnt=3 → light stays 010, cnt holds 3; after en=1, GREEN lasts 3 more cycles (6 enabled cycles total).
- ped_req pulse during RED → next GREEN lasts exactly 2 cycles; ped_ack=1 and phase_start=1 in the first YELLOW cycle.
- ped_req pulse at GREEN cnt=2 → GREEN ends after the cnt=3 cycle (4 cycles total); ped_ack pulses once; the following GREEN lasts 6.
- rst_n low mid-YELLOW, between clock edges → light=100, phase=0, ped_ack=0 immediately; after release, RED lasts 8 cycles.
- All TICKS=1, MIN_GREEN=1 → light sequence 100, 010, 001 repeating every cycle; with LAMP_PED_EN undefined, ped_req held high never asserts ped_ack.
